uart_word_tx: RTL and testbench
===============================

# uart_word_tx

Serializes 32-bit words onto a UART line as little-endian byte frames, forming the transmit counterpart of the CPU's UART program/data loader. It sits at the CPU top level: a bench-side or on-chip producer hands it one word at a time over a valid/ready handshake. The block emits `WORD_BYTES` standard 8N1 frames per word, back to back, with no idle gap between them. This lets the loader receive `CELL_NUMBERS` instruction words, and lets the CPU stream results such as `alu_result` back out.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal range ≥ 2.
- `WORD_BYTES`, 4: bytes per word, sent LSB byte first; `word_in` width is 8·`WORD_BYTES`.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `word_in` input 32: word to send; sampled only at handshake.
- `word_valid` input 1: producer has a word.
- `word_ready` output 1: block can accept a word; high only in IDLE.
- `tx` output 1: serial line; idle/mark = 1.
- `busy` output 1: high from the cycle after accept until the final stop bit completes.
- `done` output 1: one-cycle pulse on the cycle the final stop bit of a word ends.

## Operation
- States: IDLE, START, DATA, PARITY (only when configured in), STOP.
- IDLE:
  - `tx`=1, `word_ready`=1.
  - If `word_valid`&&`word_ready` at an edge: latch `word_in` into shift register, byte_idx=0, bit counter cleared, go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit_idx=0.
- DATA:
  - `tx`=current byte bit[bit_idx], LSB first, each bit held `CLKS_PER_BIT` cycles.
  - After bit 7: go to PARITY if configured, else STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then:
  - If byte_idx < `WORD_BYTES`-1: byte_idx++, go to START directly, so the next start bit follows immediately.
  - Else: pulse `done`, go to IDLE.
- Byte order: byte 0 = `word_in[7:0]` first, byte 3 = `word_in[31:24]` last.
- Latched word is immune to later changes on `word_in`.
- `word_valid` while not ready is ignored; there is no queuing.
- Counters:
  - Baud counter is sized $clog2(`CLKS_PER_BIT`) and wraps at `CLKS_PER_BIT`-1.
  - bit_idx is 3 bits; byte_idx is $clog2(`WORD_BYTES`) bits.

## Timing
- Reset (async, `rst`=0): state IDLE, `tx`=1, `word_ready`=1, `busy`=0, `done`=0, all counters 0, shift register 0.
- Reset asserted mid-frame: `tx` returns to 1 immediately, without waiting for a clock edge; the partial word is dropped.
- Accept at edge N:
  - `word_ready`=0 and `tx`=0 (start bit) from N+1.
  - `busy`=1 from N+1.
- Frame length: F = 10 bits, or 11 with parity.
- Word duration: `WORD_BYTES`·F·`CLKS_PER_BIT` cycles, starting at N+1.
- `done`=1 for exactly one cycle: the last cycle of the final stop bit.
  - `word_ready`=1 and `busy`=0 on the following cycle.
  - A new word may be accepted on that same cycle; its start bit then follows with zero extra idle cycles.
- Outputs are registered; `tx` has no combinational path from inputs.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP, F=11.
  - `tx` = XOR of the 8 data bits (even parity), held `CLKS_PER_BIT` cycles.
- Not defined: PARITY state and logic absent, F=10 (8N1).
- The loader on the other end must be built with the matching setting.

## Structure
- Shared package `uart_pkg` holds:
  - state enum `uart_tx_state_t`;
  - constants `UART_START_BIT`=0, `UART_STOP_BIT`=1, `UART_DATA_BITS`=8;
  - default `CLKS_PER_BIT`.
- Sub-module `uart_baud_tick`:
  - Inputs: `clk`, `rst`, `clear`.
  - Output: `tick` pulse every `CLKS_PER_BIT` cycles.
  - Reused by the receiver side.
- FSM, shift register and byte/bit indices live in `uart_word_tx`.

## Test plan
- Reset: hold `rst`=0 for 5 cycles → `tx`=1, `word_ready`=1, `busy`=0, `done`=0 throughout.
- Single word, `CLKS_PER_BIT`=4: send 0x00000004 (the XORI expected result).
  - Bench-side UART receiver decodes bytes 0x04, 0x00, 0x00, 0x00 in order.
  - `done` pulses at cycle 160 after accept.
- Back-to-back: hold `word_valid`=1 with 0xDEADBEEF then 0x12345678.
  - Second accept occurs on the `done`+1 cycle.
  - Bytes EF BE AD DE 78 56 34 12 arrive with no idle bit between frames.
- Input stability: change `word_in` to 0xFFFFFFFF one cycle after accepting 0xA5A5A5A5 → line carries A5 ×4; `valid` while busy is ignored.
- Reset mid-frame: drop `rst` during DATA of byte 2.
  - `tx`=1 asynchronously, `word_ready`=1.
  - A subsequent word 0x0000007F is sent cleanly.
- With `UART_TX_PARITY_EN`: send 0x00000307.
  - Parity bits are 1, 0, 0, 0.
  - F=11, and `done` pulses at cycle 176 after accept (`CLKS_PER_BIT`=4).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the word transmitter and the loader-side receiver.
// UART_TX_PARITY_EN adds the even-parity state to the transmitter state set.
package uart_pkg;

    localparam int   UART_CLKS_PER_BIT = 16;
    localparam int   UART_DATA_BITS    = 8;
    localparam logic UART_START_BIT    = 1'b0;
    localparam logic UART_STOP_BIT     = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
`ifdef UART_TX_PARITY_EN
        , ST_PARITY
`endif
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high on the last cycle of every CLKS_PER_BIT-cycle bit.
// Holding clear parks the count at zero so the first bit after release is full length.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_word_tx.sv
// Sends one WORD_BYTES-wide word as back-to-back 8N1 frames, least significant byte first.
// Define UART_TX_PARITY_EN to append an even-parity bit to every frame (8E1).
//
// state  | meaning
// IDLE   | line at mark, ready for a new word
// START  | start bit of the current byte
// DATA   | data bits, LSB first
// PARITY | even parity of the current byte (UART_TX_PARITY_EN only)
// STOP   | stop bit; chains straight into the next byte's START
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int WORD_BYTES   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8*WORD_BYTES-1:0]   word_in,
    input  logic                      word_valid,
    output logic                      word_ready,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);

    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_BYTES - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t          state_q, state_d;
    logic [8*WORD_BYTES-1:0] shreg_q, shreg_d;
    logic [2:0]              bit_idx_q, bit_idx_d;
    logic [BW-1:0]           byte_idx_q, byte_idx_d;
    logic                    tick;
    logic [7:0]              byte_cur;

    assign byte_cur = shreg_q[7:0];

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == ST_IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (word_valid) begin
                    state_d    = ST_START;
                    shreg_d    = word_in;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Next byte moves into the low lane; no idle gap between frames.
                        state_d    = ST_START;
                        byte_idx_d = byte_idx_q + BW'(1);
                        shreg_d    = shreg_q >> 8;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx         = UART_STOP_BIT;
        word_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                word_ready = 1'b1;
                busy       = 1'b0;
            end
            ST_START:  tx = UART_START_BIT;
            ST_DATA:   tx = byte_cur[bit_idx_q];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = ^byte_cur;
`endif
            ST_STOP:   done = tick && (byte_idx_q == LAST_BYTE);
            default:   tx = UART_STOP_BIT;
        endcase
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: expected line levels come from a frame model
// built from the UART framing rules, plus a mid-bit sampling receiver for byte decode.
module tb_uart_word_tx;

    localparam int CPB = 4;
    localparam int WB  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    localparam int L = WB * F * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready, tx, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_word_tx #(
        .CLKS_PER_BIT(CPB),
        .WORD_BYTES  (WB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .word_in   (word_in),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level during cycle k (1-based, counted from the accept edge) of word w.
    function automatic logic exp_line(input logic [31:0] w, input int k);
        int         bit_no = (k - 1) / CPB;
        int         pos    = bit_no % F;
        logic [7:0] by     = 8'(w >> (8 * (bit_no / F)));
        if (pos == 0) return 1'b0;
        if (pos <= 8) return by[pos-1];
        if (pos == F - 1) return 1'b1;
        return ^by;
    endfunction

    task automatic idle_checks(input string tag);
        chk({tag, "_tx"}, tx, 1);
        chk({tag, "_ready"}, word_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Called at a negedge; returns at the negedge of the cycle after done.
    task automatic run_word(input logic [31:0] w, input logic [31:0] during_word,
                            input logic during_valid);
        logic [WB*F-1:0] rx;
        logic [7:0]      rbyte;
        rx = '0;
        word_in    = w;
        word_valid = 1'b1;
        chk("ready_before_accept", word_ready, 1);
        @(posedge clk);
        @(negedge clk);
        word_in    = during_word;
        word_valid = during_valid;
        for (int k = 1; k <= L; k++) begin
            if (k > 1) @(negedge clk);
            chk("tx_line", tx, exp_line(w, k));
            chk("busy_in_word", busy, 1);
            chk("ready_in_word", word_ready, 0);
            chk("done_timing", done, (k == L));
            if ((k - 1) % CPB == CPB / 2) rx[(k-1)/CPB] = tx;
        end
        @(negedge clk);
        chk("after_done_ready", word_ready, 1);
        chk("after_done_busy", busy, 0);
        chk("after_done_done", done, 0);
        chk("after_done_tx", tx, 1);
        for (int b = 0; b < WB; b++) begin
            rbyte = rx[b*F+1 +: 8];
            chk("rx_start", rx[b*F], 0);
            chk("rx_byte", rbyte, 8'(w >> (8 * b)));
`ifdef UART_TX_PARITY_EN
            chk("rx_parity", rx[b*F+9], ^rbyte);
`endif
            chk("rx_stop", rx[b*F+F-1], 1);
        end
    endtask

    initial begin
        logic [31:0] w;
        int          kr;

        repeat (5) begin
            @(negedge clk);
            idle_checks("reset");
        end
        rst = 1'b1;
        @(negedge clk);
        idle_checks("post_reset");

        run_word(32'h0000_0004, 32'h0, 1'b0);

        run_word(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        run_word(32'h1234_5678, 32'h0, 1'b0);

        run_word(32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b1);
        word_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            idle_checks("no_queue");
        end

        repeat (4) begin
            w = $urandom;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_word(w, $urandom, 1'b0);
        end

        run_word(32'h0000_0307, 32'h0, 1'b0);

        w          = $urandom;
        word_in    = w;
        word_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        word_valid = 1'b0;
        kr = 2 * F * CPB + CPB + 3;
        for (int k = 2; k <= kr; k++) @(negedge clk);
        chk("midframe_tx", tx, exp_line(w, kr));
        chk("midframe_busy", busy, 1);
        #2 rst = 1'b0;
        #1 idle_checks("async_reset");
        repeat (2) begin
            @(negedge clk);
            idle_checks("held_reset");
        end
        rst = 1'b1;
        @(negedge clk);
        idle_checks("after_reset_release");
        run_word(32'h0000_007F, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
